// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running h/v counters with registered
// blank/sync/coordinate/strobe decode and a completed-frame counter.
// All state advances only on pix_en_i; restart_i realigns the raster to (0,0).
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 12,
    parameter int FW       = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          pix_en_i,
    input  logic          restart_i,
    output logic          blank_o,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic [CW-1:0] xpos_o,
    output logic [CW-1:0] ypos_o,
    output logic          sof_o,
    output logic          eol_o,
    output logic [FW-1:0] frame_cnt_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int CWE     = CW + 1;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

    // Region bounds are one bit wider than the counters so a boundary equal
    // to 2^CW (total exactly filling the counter) does not alias to zero.
    localparam logic [CW:0] H_ACT_END = CWE'(H_ACTIVE);
    localparam logic [CW:0] V_ACT_END = CWE'(V_ACTIVE);
    localparam logic [CW:0] HS_START  = CWE'(H_ACTIVE + H_FP);
    localparam logic [CW:0] HS_LEN    = CWE'(H_SYNC);
    localparam logic [CW:0] VS_START  = CWE'(V_ACTIVE + V_FP);
    localparam logic [CW:0] VS_LEN    = CWE'(V_SYNC);

    logic [CW-1:0] hc_q, hc_d, vc_q, vc_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic          blank_q, blank_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          sof_q, sof_d;
    logic          eol_q, eol_d;
    logic [CW-1:0] xpos_q, ypos_q;
    logic [CW:0]   hc_ext, vc_ext;
    logic          h_wrap, v_wrap, hs_act, vs_act;

    // Next counter values and decode of the current (hc, vc) position.
    always_comb begin
        hc_ext = {1'b0, hc_q};
        vc_ext = {1'b0, vc_q};
        h_wrap = (hc_q == H_LAST);
        v_wrap = (vc_q == V_LAST);

        hc_d = h_wrap ? '0 : hc_q + CW'(1);
        vc_d = vc_q;
        if (h_wrap) begin
            vc_d = v_wrap ? '0 : vc_q + CW'(1);
        end

        // A restart coinciding with the natural wrap still counts that
        // frame exactly once.
        frame_cnt_d = frame_cnt_q;
        if (h_wrap && v_wrap) begin
            frame_cnt_d = frame_cnt_q + FW'(1);
        end

        if (restart_i) begin
            hc_d = '0;
            vc_d = '0;
        end

        // Offset-and-length compare: an empty sync window never matches and
        // a zero start needs no always-true lower bound.
        hs_act  = (hc_ext - HS_START) < HS_LEN;
        vs_act  = (vc_ext - VS_START) < VS_LEN;
        blank_d = !((hc_ext < H_ACT_END) && (vc_ext < V_ACT_END));
        hsync_d = hs_act ? HS_POL : ~HS_POL;
        vsync_d = vs_act ? VS_POL : ~VS_POL;
        sof_d   = (hc_q == '0) && (vc_q == '0);
        eol_d   = h_wrap;
    end

    // Counters and registered outputs; everything holds while pix_en_i is low.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hc_q        <= '0;
            vc_q        <= '0;
            frame_cnt_q <= '0;
            blank_q     <= 1'b1;
            hsync_q     <= ~HS_POL;
            vsync_q     <= ~VS_POL;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
            xpos_q      <= '0;
            ypos_q      <= '0;
        end else if (pix_en_i) begin
            hc_q        <= hc_d;
            vc_q        <= vc_d;
            frame_cnt_q <= frame_cnt_d;
            blank_q     <= blank_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            sof_q       <= sof_d;
            eol_q       <= eol_d;
            xpos_q      <= hc_q;
            ypos_q      <= vc_q;
        end
    end

    assign blank_o     = blank_q;
    assign hsync_o     = hsync_q;
    assign vsync_o     = vsync_q;
    assign xpos_o      = xpos_q;
    assign ypos_o      = ypos_q;
    assign sof_o       = sof_q;
    assign eol_o       = eol_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: three instances (default VGA mode, a tiny
// positive-polarity mode with a 2-bit frame counter, and a mode with empty
// porches/hsync) checked every cycle against a position-count model.
module tb_video_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b1;
    logic pe [3];
    logic rs [3];

    logic        o_blank [3];
    logic        o_hs    [3];
    logic        o_vs    [3];
    logic        o_sof   [3];
    logic        o_eol   [3];
    logic [11:0] o_x     [3];
    logic [11:0] o_y     [3];
    logic [15:0] fc0;
    logic [1:0]  fc1;
    logic [3:0]  fc2;

    video_timing_gen u_def (
        .clk_i(clk), .rst_ni(rst_n), .pix_en_i(pe[0]), .restart_i(rs[0]),
        .blank_o(o_blank[0]), .hsync_o(o_hs[0]), .vsync_o(o_vs[0]),
        .xpos_o(o_x[0]), .ypos_o(o_y[0]), .sof_o(o_sof[0]), .eol_o(o_eol[0]),
        .frame_cnt_o(fc0)
    );

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(12), .FW(2)
    ) u_sm (
        .clk_i(clk), .rst_ni(rst_n), .pix_en_i(pe[1]), .restart_i(rs[1]),
        .blank_o(o_blank[1]), .hsync_o(o_hs[1]), .vsync_o(o_vs[1]),
        .xpos_o(o_x[1]), .ypos_o(o_y[1]), .sof_o(o_sof[1]), .eol_o(o_eol[1]),
        .frame_cnt_o(fc1)
    );

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(0), .H_SYNC(0), .H_BP(2),
        .V_ACTIVE(2), .V_FP(0), .V_SYNC(1), .V_BP(0),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(12), .FW(4)
    ) u_dg (
        .clk_i(clk), .rst_ni(rst_n), .pix_en_i(pe[2]), .restart_i(rs[2]),
        .blank_o(o_blank[2]), .hsync_o(o_hs[2]), .vsync_o(o_vs[2]),
        .xpos_o(o_x[2]), .ypos_o(o_y[2]), .sof_o(o_sof[2]), .eol_o(o_eol[2]),
        .frame_cnt_o(fc2)
    );

    localparam int HA_T [3] = '{640, 4, 4};
    localparam int HF_T [3] = '{16, 1, 0};
    localparam int HS_T [3] = '{96, 2, 0};
    localparam int HB_T [3] = '{48, 1, 2};
    localparam int VA_T [3] = '{480, 3, 2};
    localparam int VF_T [3] = '{10, 1, 0};
    localparam int VS_T [3] = '{2, 1, 1};
    localparam int VB_T [3] = '{33, 1, 0};
    localparam int HP_T [3] = '{0, 1, 0};
    localparam int VP_T [3] = '{0, 1, 0};
    localparam int FW_T [3] = '{16, 2, 4};

    // Model: k = enabled ticks since the raster origin (mod frame length).
    int          k     [3];
    int          fc    [3];
    logic [44:0] exp_v [3];

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    function automatic logic [44:0] pack(input bit b, input bit hs, input bit vs,
                                         input bit sof, input bit eol,
                                         input int x, input int y, input int f);
        return {b, hs, vs, sof, eol, 12'(x), 12'(y), 16'(f)};
    endfunction

    function automatic logic [44:0] act_vec(input int i);
        logic [15:0] f;
        case (i)
            0:       f = fc0;
            1:       f = {14'b0, fc1};
            default: f = {12'b0, fc2};
        endcase
        return {o_blank[i], o_hs[i], o_vs[i], o_sof[i], o_eol[i], o_x[i], o_y[i], f};
    endfunction

    task automatic model_reset(input int i);
        k[i]     = 0;
        fc[i]    = 0;
        exp_v[i] = pack(1'b1, bit'(1 - HP_T[i]), bit'(1 - VP_T[i]), 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic model_tick(input int i, input bit r);
        int ht, vt, h, v, hs0, vs0;
        bit hs, vs, b;
        ht  = HA_T[i] + HF_T[i] + HS_T[i] + HB_T[i];
        vt  = VA_T[i] + VF_T[i] + VS_T[i] + VB_T[i];
        h   = k[i] % ht;
        v   = k[i] / ht;
        hs0 = HA_T[i] + HF_T[i];
        vs0 = VA_T[i] + VF_T[i];
        hs  = (h >= hs0) && (h < hs0 + HS_T[i]);
        vs  = (v >= vs0) && (v < vs0 + VS_T[i]);
        b   = !((h < HA_T[i]) && (v < VA_T[i]));
        if (k[i] == ht * vt - 1) fc[i] = (fc[i] + 1) % (1 << FW_T[i]);
        exp_v[i] = pack(b, bit'(hs ? HP_T[i] : 1 - HP_T[i]), bit'(vs ? VP_T[i] : 1 - VP_T[i]),
                        (h == 0) && (v == 0), h == ht - 1, h, v, fc[i]);
        k[i] = r ? 0 : (k[i] + 1) % (ht * vt);
    endtask

    task automatic chk_vec(input string name, input logic [44:0] a, input logic [44:0] e);
        total_cnt++;
        if (a === e) pass_cnt++;
        else $display("FAIL %s: got {blank,hs,vs,sof,eol,x,y,fc}=%h expected %h", name, a, e);
    endtask

    task automatic chk_int(input string name, input int a, input int e);
        total_cnt++;
        if (a == e) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, a, e);
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++)
            chk_vec($sformatf("inst%0d cycle %0d", i, cyc), act_vec(i), exp_v[i]);
    endtask

    task automatic step(input bit p0, input bit p1, input bit p2,
                        input bit r0, input bit r1, input bit r2);
        pe[0] = p0; pe[1] = p1; pe[2] = p2;
        rs[0] = r0; rs[1] = r1; rs[2] = r2;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (!rst_n)     model_reset(i);
            else if (pe[i]) model_tick(i, rs[i]);
        end
        #1;
        cyc++;
        compare_all();
    endtask

    int fseq [5] = '{1, 2, 3, 0, 1};
    int cap;

    initial begin
        for (int i = 0; i < 3; i++) begin
            pe[i] = 1'b0;
            rs[i] = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) model_reset(i);
        compare_all();
        chk_int("reset sm hsync", o_hs[1], 0);
        chk_int("reset def blank", o_blank[0], 1);
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 1, 1, 1);
        rst_n = 1'b1;

        // Continuous run from reset: default lines and five small frames.
        for (int n = 1; n <= 8100; n++) begin
            step(1, 1, 1, 0, 0, 0);
            if (n == 640) chk_int("def blank x639", o_blank[0], 0);
            if (n == 641) chk_int("def blank x640", o_blank[0], 1);
            if (n == 656) chk_int("def hsync x655", o_hs[0], 1);
            if (n == 657) chk_int("def hsync x656", o_hs[0], 0);
            if (n == 752) chk_int("def hsync x751", o_hs[0], 0);
            if (n == 753) chk_int("def hsync x752", o_hs[0], 1);
            if (n == 800) chk_int("def eol x799", o_eol[0], 1);
            if (n == 801) chk_int("def y line1", o_y[0], 1);
            if (n == 1)   chk_int("sm first sof", o_sof[1], 1);
            if (n == 1)   chk_int("sm first blank", o_blank[1], 0);
            if (n == 6)   chk_int("sm hsync x5", o_hs[1], 1);
            if (n == 8)   chk_int("sm hsync x7", o_hs[1], 0);
            if (n == 32)  chk_int("sm vsync line3", o_vs[1], 0);
            if (n == 33)  chk_int("sm vsync line4", o_vs[1], 1);
            if (n == 13)  chk_int("dg vsync line2", o_vs[2], 0);
            if (n % 48 == 0 && n <= 240) chk_int($sformatf("sm fc frame%0d", n / 48), fc1, fseq[n / 48 - 1]);
        end

        // Small instance with pix_en toggling.
        for (int n = 0; n < 96; n++) step(1, bit'(n % 2 == 0), 1, 0, 0, 0);

        // Restart at (2,1), then at the natural wrap (7,5).
        for (int t = 0; t < 60 && k[1] != 10; t++) step(1, 1, 1, 0, 0, 0);
        cap = fc[1];
        step(1, 1, 1, 0, 1, 0);
        chk_int("sm restart pos x", o_x[1], 2);
        chk_int("sm restart pos y", o_y[1], 1);
        step(1, 1, 1, 0, 0, 0);
        chk_int("sm after restart sof", o_sof[1], 1);
        chk_int("sm after restart x", o_x[1], 0);
        chk_int("sm after restart fc", fc1, cap);
        for (int t = 0; t < 60 && k[1] != 47; t++) step(1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 1, 0);
        chk_int("sm wrap+restart eol", o_eol[1], 1);
        chk_int("sm wrap+restart fc", fc1, (cap + 1) % 4);
        step(1, 1, 1, 0, 0, 0);
        chk_int("sm wrap+restart sof", o_sof[1], 1);
        chk_int("sm wrap+restart fc once", fc1, (cap + 1) % 4);

        // Random enables and occasional restarts.
        for (int n = 0; n < 3000; n++)
            step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                 $urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);

        // Asynchronous reset between clock edges.
        for (int n = 0; n < 21; n++) step(1, 1, 1, 0, 0, 0);
        #3 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) model_reset(i);
        compare_all();
        chk_int("async rst sm blank", o_blank[1], 1);
        chk_int("async rst def x", o_x[0], 0);
        chk_int("async rst sm fc", fc1, 0);
        step(1, 1, 1, 0, 0, 0);
        rst_n = 1'b1;
        #2;
        for (int n = 1; n <= 200; n++) begin
            step(1, 1, 1, 0, 0, 0);
            if (n == 1) chk_int("post rst sm sof", o_sof[1], 1);
            if (n == 2) chk_int("post rst sm x", o_x[1], 1);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
